// File: rtl/sao_band_apply_n5.sv
// sao_band_apply_n5: SAO band-offset apply, PIX5 pixels per beat, one CTB per configuration.
// Optional feature macro: SAO_APPLY_MODCNT_EN adds mod_cnt, the per-CTB count of modified samples.
// Ports:
//   clk, arst_n (async, active-low), rst_n (sync, active-low, same effect as arst_n)
//   cfg_valid/cfg_ready, cfg_band_pos, cfg_offset[0:3], cfg_nbeat : CTB configuration handshake
//   in_valid/in_ready, in_pix[0:PIX5-1]                            : deblocked pixel beats
//   out_valid/out_ready, out_pix[0:PIX5-1]                         : SAO-corrected pixel beats
//   ctb_done                                                       : one-cycle pulse once the CTB has drained
//   mod_cnt (SAO_APPLY_MODCNT_EN only)                             : modified-sample count, valid at ctb_done
module sao_band_apply_n5 #(
  parameter int unsigned PIX5          = 5,
  parameter int unsigned BIT_DEPTH     = 8,
  parameter int unsigned diff_clip_bit = 4
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [4:0]                    cfg_band_pos,
  input  logic signed [diff_clip_bit:0] cfg_offset [0:3],
  input  logic [9:0]                    cfg_nbeat,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIT_DEPTH-1:0]          in_pix [0:PIX5-1],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIT_DEPTH-1:0]          out_pix [0:PIX5-1],
  output logic                          ctb_done
`ifdef SAO_APPLY_MODCNT_EN
  ,
  output logic [9:0]                    mod_cnt
`endif
);

  localparam int unsigned SW    = BIT_DEPTH + 2;
  localparam int unsigned SHIFT = BIT_DEPTH - 8;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e                        state_q;
  logic [9:0]                    beats_left_q;
  logic [4:0]                    band_pos_q;
  logic signed [diff_clip_bit:0] offset_q [0:3];
  logic                          s1_valid_q;
  logic [BIT_DEPTH-1:0]          s1_pix_q [0:PIX5-1];
  logic [1:0]                    s1_k_q   [0:PIX5-1];
  logic                          s1_hit_q [0:PIX5-1];
  logic                          out_valid_q;
  logic [BIT_DEPTH-1:0]          out_pix_q [0:PIX5-1];
  logic                          ctb_done_q;

  logic                          rst_ok_c;
  logic                          en_c;
  logic                          cfg_fire_c;
  logic                          in_fire_c;
  logic [1:0]                    s1_k_d   [0:PIX5-1];
  logic                          s1_hit_d [0:PIX5-1];
  logic signed [SW-1:0]          off_c    [0:PIX5-1];
  logic signed [SW-1:0]          sum_c    [0:PIX5-1];
  logic [BIT_DEPTH-1:0]          out_d    [0:PIX5-1];

  // Handshakes are forced low while either reset is asserted.
  assign rst_ok_c   = arst_n && rst_n;
  assign en_c       = !out_valid_q || out_ready;
  assign cfg_ready  = rst_ok_c && (state_q == ST_IDLE);
  assign in_ready   = rst_ok_c && (state_q == ST_RUN) && (beats_left_q != 10'd0) && en_c;
  assign cfg_fire_c = cfg_valid && cfg_ready;
  assign in_fire_c  = in_valid && in_ready;

  assign out_valid  = out_valid_q;
  assign out_pix    = out_pix_q;
  assign ctb_done   = ctb_done_q;

  // Stage 1: band classification; the 5-bit subtraction wraps mod 32 so band_pos 30 reaches bands 0 and 1.
  always_comb begin
    for (int i = 0; i < PIX5; i++) begin
      logic [4:0] k;
      k           = in_pix[i][BIT_DEPTH-1 -: 5] - band_pos_q;
      s1_k_d[i]   = k[1:0];
      s1_hit_d[i] = (k[4:2] == 3'd0);
    end
  end

  // Stage 2: add the scaled offset at BIT_DEPTH+2 signed width, then clip to [0, 2^BIT_DEPTH-1].
  always_comb begin
    for (int i = 0; i < PIX5; i++) begin
      off_c[i] = '0;
      if (s1_hit_q[i]) off_c[i] = SW'(offset_q[s1_k_q[i]]) <<< SHIFT;
      sum_c[i] = $signed({2'b00, s1_pix_q[i]}) + off_c[i];
      if (sum_c[i][SW-1])      out_d[i] = '0;
      else if (sum_c[i][SW-2]) out_d[i] = '1;
      else                     out_d[i] = sum_c[i][BIT_DEPTH-1:0];
    end
  end

  // Control FSM, config registers and the two pipeline stages.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      band_pos_q   <= '0;
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      ctb_done_q   <= 1'b0;
      for (int j = 0; j < 4; j++) offset_q[j] <= '0;
      for (int i = 0; i < PIX5; i++) begin
        s1_pix_q[i]  <= '0;
        s1_k_q[i]    <= '0;
        s1_hit_q[i]  <= 1'b0;
        out_pix_q[i] <= '0;
      end
    end else if (!rst_n) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      band_pos_q   <= '0;
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      ctb_done_q   <= 1'b0;
      for (int j = 0; j < 4; j++) offset_q[j] <= '0;
      for (int i = 0; i < PIX5; i++) begin
        s1_pix_q[i]  <= '0;
        s1_k_q[i]    <= '0;
        s1_hit_q[i]  <= 1'b0;
        out_pix_q[i] <= '0;
      end
    end else begin
      ctb_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_fire_c) begin
            band_pos_q   <= cfg_band_pos;
            for (int j = 0; j < 4; j++) offset_q[j] <= cfg_offset[j];
            beats_left_q <= (cfg_nbeat == 10'd0) ? 10'd1 : cfg_nbeat;
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_fire_c) begin
            beats_left_q <= beats_left_q - 10'd1;
            if (beats_left_q == 10'd1) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Stage 1 empty and stage 2 leaving (or empty) means both are empty after this edge.
          if (en_c && !s1_valid_q) begin
            ctb_done_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (en_c) begin
        s1_valid_q  <= in_fire_c;
        out_valid_q <= s1_valid_q;
        for (int i = 0; i < PIX5; i++) begin
          if (in_fire_c) begin
            s1_pix_q[i] <= in_pix[i];
            s1_k_q[i]   <= s1_k_d[i];
            s1_hit_q[i] <= s1_hit_d[i];
          end
          if (s1_valid_q) out_pix_q[i] <= out_d[i];
        end
      end
    end
  end

`ifdef SAO_APPLY_MODCNT_EN
  logic [9:0]  mod_cnt_q;
  logic [10:0] mod_sum_c;

  assign mod_cnt = mod_cnt_q;

  // A sample counts as modified only when its offset is applied and the clipped result differs.
  always_comb begin
    mod_sum_c = 11'(mod_cnt_q);
    for (int i = 0; i < PIX5; i++) begin
      if (s1_hit_q[i] && (out_d[i] != s1_pix_q[i])) mod_sum_c = mod_sum_c + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mod_cnt_q <= '0;
    end else if (!rst_n) begin
      mod_cnt_q <= '0;
    end else if (cfg_fire_c) begin
      mod_cnt_q <= '0;
    end else if (en_c && s1_valid_q) begin
      mod_cnt_q <= (mod_sum_c > 11'd1023) ? 10'd1023 : mod_sum_c[9:0];
    end
  end
`endif

endmodule
